// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBrkWait
   } rx_fsm_t;

   localparam int unsigned LcrWlsLo = 0;
   localparam int unsigned LcrWlsHi = 1;
   localparam int unsigned LcrStb   = 2;
   localparam int unsigned LcrPen   = 3;
   localparam int unsigned LcrEpsLo = 3;
   localparam int unsigned LcrEpsHi = 5;

   localparam logic [2:0] ParOdd   = 3'b001;
   localparam logic [2:0] ParEven  = 3'b011;
   localparam logic [2:0] ParMark  = 3'b101;
   localparam logic [2:0] ParSpace = 3'b111;

   localparam logic [3:0] OsMid  = 4'd7;
   localparam logic [3:0] OsLast = 4'd15;

   typedef struct packed {
      logic       bi;
      logic       fe;
      logic       pe;
      logic [7:0] data;
   } rx_entry_t;

   function automatic logic exp_parity(input logic [2:0] mode, input logic [7:0] d);
      logic p;
      case (mode)
         ParOdd:  p = ~^d;
         ParEven: p = ^d;
         ParMark: p = 1'b1;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX FIFO; a push while full is dropped and flagged unless a pop frees the slot.
module uart_rx_fifo #(
   parameter int unsigned Depth = 16,
   parameter int unsigned Width = 11
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         data_i,
   output logic [Width-1:0]         data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     overflow_o
);

   localparam int unsigned Aw = $clog2(Depth);
   localparam logic [Aw:0] CountFull = (Aw+1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Aw-1:0]    wptr_q, rptr_q;
   logic [Aw:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CountFull);
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && (!full_o || do_pop);
   assign overflow_o = push_i && full_o && !do_pop;
   assign count_o    = count_q;
   assign data_o     = empty_o ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: RXD synchroniser, 16x-oversampled frame FSM and RX FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         PCLK,
   input  logic                         PRESETn,
   input  logic                         RXD,
   input  logic [7:0]                   LCR,
   input  logic                         enable,
   input  logic                         rx_fifo_pop,
   input  logic                         clear_overrun,
   output logic [10:0]                  rx_fifo_out,
   output logic                         rx_fifo_empty,
   output logic                         rx_fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]  rx_fifo_count,
   output logic                         rx_overrun,
   output logic                         busy
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   rx_fsm_t                state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             data_q, data_d;
   logic                   par_q, par_d;
   logic                   pe_q, pe_d;
   logic                   push_q, push_d;
   rx_entry_t              entry_q, entry_d;
   logic                   overrun_q, overrun_d;
   logic                   overflow;
   logic [2:0]             last_idx;
   logic                   fe;
   logic                   unused_lcr;

   assign rxd_s      = sync_q[SYNC_STAGES-1];
   assign last_idx   = 3'd4 + {1'b0, LCR[LcrWlsHi:LcrWlsLo]};
   assign fe         = !rxd_s;
   assign busy       = (state_q != StIdle);
   assign rx_overrun = overrun_q;
   assign unused_lcr = ^{LCR[7:6], LCR[LcrStb]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      par_d   = par_q;
      pe_d    = pe_q;
      push_d  = 1'b0;
      entry_d = entry_q;
      if (enable) begin
         unique case (state_q)
            StIdle: begin
               if (!rxd_s) begin
                  state_d = StStart;
                  cnt_d   = '0;
               end
            end
            StStart: begin
               if (cnt_q == OsMid) begin
                  if (rxd_s) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StData;
                     cnt_d   = '0;
                     idx_d   = '0;
                     data_d  = '0;
                     par_d   = 1'b0;
                     pe_d    = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StData: begin
               if (cnt_q == OsLast) begin
                  cnt_d         = '0;
                  data_d[idx_q] = rxd_s;
                  if (idx_q == last_idx) state_d = LCR[LcrPen] ? StParity : StStop;
                  else                   idx_d   = idx_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StParity: begin
               if (cnt_q == OsLast) begin
                  cnt_d   = '0;
                  par_d   = rxd_s;
                  pe_d    = rxd_s != exp_parity(LCR[LcrEpsHi:LcrEpsLo], data_q);
                  state_d = StStop;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StStop: begin
               if (cnt_q == OsLast) begin
                  cnt_d        = '0;
                  push_d       = 1'b1;
                  entry_d.data = data_q;
                  entry_d.pe   = pe_q;
                  entry_d.fe   = fe;
                  // A break is a full frame of zeros, parity bit included.
                  entry_d.bi   = fe && (data_q == '0) && !par_q;
                  state_d      = rxd_s ? StIdle : StBrkWait;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StBrkWait: begin
               if (rxd_s) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      overrun_d = overrun_q;
      if (clear_overrun) overrun_d = 1'b0;
      if (overflow)      overrun_d = 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sync_q    <= '1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         pe_q      <= 1'b0;
         push_q    <= 1'b0;
         entry_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], RXD};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         par_q     <= par_d;
         pe_q      <= pe_d;
         push_q    <= push_d;
         entry_q   <= entry_d;
         overrun_q <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (11)
   ) u_fifo (
      .clk_i      (PCLK),
      .rst_ni     (PRESETn),
      .push_i     (push_q),
      .pop_i      (rx_fifo_pop),
      .data_i     (entry_q),
      .data_o     (rx_fifo_out),
      .empty_o    (rx_fifo_empty),
      .full_o     (rx_fifo_full),
      .count_o    (rx_fifo_count),
      .overflow_o (overflow)
   );

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage that consumes the line driven by the UART transmitter (directly, in loopback, or from the external RXD pin).
- Deserialises 5–8 data bits with optional parity at 16x oversampling, qualified by the same baud `enable` tick the transmitter uses.
- Checks parity, framing and break, and pushes data plus error flags into an internal RX FIFO.
- The APB register block pops that FIFO.

Parameters:
- FIFO_DEPTH, 16, number of RX FIFO entries (power of two).
- SYNC_STAGES, 2, number of flops in the RXD synchroniser chain.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  reset. Asynchronous, active-low.
- RXD  in  1  serial input. Asynchronous to PCLK; idle high.
- LCR  in  8  line control. [1:0] word length 5/6/7/8. [2] stop bits, ignored by RX. [3] parity enable. [5:3] parity mode, same encoding as TX.
- enable  in  1  16x baud tick, one PCLK wide.
- rx_fifo_pop  in  1  pop the head entry. Ignored when empty.
- clear_overrun  in  1  one-cycle pulse; clears rx_overrun.
- rx_fifo_out  out  11  head entry, show-ahead. [7:0] data, zero-extended. [8] PE. [9] FE. [10] BI.
- rx_fifo_empty  out  1  FIFO empty.
- rx_fifo_full  out  1  FIFO full.
- rx_fifo_count  out  5  number of valid entries, 0..16.
- rx_overrun  out  1  sticky: a frame was lost because the FIFO was full.
- busy  out  1  high from start detection until return to IDLE.

Behaviour:
- Reset values, all asserted asynchronously on PRESETn=0:
  - State machine in IDLE; bit counter 0.
  - Synchroniser flops 1; FIFO emptied.
  - busy 0, rx_overrun 0, rx_fifo_empty 1, rx_fifo_full 0, rx_fifo_count 0, rx_fifo_out 0.
- Reset mid-frame aborts the frame; no partial entry is pushed.
- All FSM actions are qualified by enable=1. With enable=0 the state and counter hold, including mid-frame.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - Data bits: shift register plus bit index, LSB first.
  - Sampled RXD means the synchroniser output.
- IDLE:
  - On an enable tick with sampled RXD=0: go to START, counter=0, busy=1.
  - Otherwise busy=0.
- START:
  - Counter increments each tick. At counter==7 (mid start bit), sample RXD.
  - Sample 1: false start, return to IDLE. Nothing is pushed.
  - Sample 0: counter=0, go to DATA with bit index 0.
- DATA:
  - Sample at counter==15, i.e. 16 ticks after the previous sample, at mid-bit.
  - Word length 5+LCR[1:0]. After the last bit, go to PARITY if LCR[3]=1, else STOP.
- PARITY:
  - Sample at counter==15. Expected value by LCR[5:3]:
    - 001: ~^data.
    - 011: ^data.
    - 101: 1.
    - 111: 0.
  - Unused data bits count as 0. PE=1 on mismatch.
- STOP:
  - Sample at counter==15. FE = (sample==0).
  - BI = FE && all data bits 0 && the parity sample (if enabled) was 0.
  - Push {BI,FE,PE,data} on the following PCLK.
  - Then go to BRK_WAIT if the sample was 0, else IDLE.
  - A second stop bit is not checked.
- BRK_WAIT: stay until sampled RXD=1, then go to IDLE. Exactly one entry is pushed per break.
- LCR is sampled live. Software changes LCR only while busy=0.
- FIFO:
  - Push on full: the entry is dropped, rx_overrun=1, FIFO contents unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. This is legal when full, in which case there is no overrun.
  - Pop on empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is $clog2(FIFO_DEPTH)+1.
- rx_overrun:
  - Cleared the cycle after clear_overrun=1.
  - If clear_overrun and a new overrun occur in the same cycle, the set wins.
- Latency: push lands in the FIFO at 8+16·(1+N+P)+1 enable ticks after the start edge is sampled, plus 1 PCLK. N = data bits, P = parity bit.

Decomposition:
- Package uart_pkg:
  - rx_fsm_t enum.
  - LCR field index constants.
  - Parity mode constants (001/011/101/111).
  - Oversample constants: MID=7, LAST=15.
  - rx_entry_t packed struct {bi, fe, pe, data[7:0]}.
- Sub-module uart_rx_fifo:
  - Parameterised by depth and width=11.
  - Ports clk, rstn, push, pop, data_in, data_out, fifo_empty, fifo_full, count, overflow pulse.
- Synchroniser and FSM stay in uart_rx.

Test Plan:
- LCR=0x03, one enable per 4 PCLK, send 8N1 frame 0xA5 → one push; count=1, rx_fifo_out=0x0A5; busy drops after STOP.
- LCR=0x1B (8 bits, even parity), send 0x01 with parity bit 0 → rx_fifo_out=0x101 (PE). Repeat with parity 1 → 0x001.
- LCR=0x00, send 0x1F (5 bits), then LCR=0x03, send 0x55 with stop bit 0 → entries 0x01F, then 0x255 (FE).
- LCR=0x03, hold RXD low for 20 bit times, then release → exactly one entry 0x600 (BI|FE); FSM stays in BRK_WAIT until RXD=1.
- Send 17 frames 0x00..0x10 without popping → count=16, full=1, rx_overrun=1, head=0x000. Pop all 16 → last entry 0x00F. clear_overrun → rx_overrun=0.
- RXD low for 4 enable ticks only → no push, busy returns to 0. Separately, assert PRESETn=0 mid-DATA → FIFO empty, busy=0, the next clean frame is received correctly.
